matmult_result_drain: RTL and testbench

Result-side companion to the 2x2 matrix multiplier. Captures the four parallel 32-bit products c00, c01, c10 and c11 on a capture strobe, then streams them out one word per beat over a valid/ready interface in row-major order. It converts the multiplier's wide parallel output into a narrow stream for downstream memory, FIFO or host logic, and flags any result it had to drop.

---
 rtl/matmult_result_drain_if.sv | 44 ++++
 rtl/matmult_result_drain.sv | 126 ++++++++++++
 tb/tb_matmult_result_drain.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmult_result_drain_if.sv
// matmult_result_drain_if: bundles the capture side and the streaming side of the result drain.
//   Capture: cap_valid, c00..c11 (to drain), cap_ready (from drain).
//   Stream : m_valid, m_data, m_idx, m_last (from drain), m_ready (to drain).
//   Status : ovf, frame_cnt (from drain), ovf_clr (to drain).
//   Optional: m_parity (from drain) when MATDRAIN_PARITY_EN is defined.
// Modport master is taken by the drain itself; slave by the surrounding logic.
interface matmult_result_drain_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
);
   logic              cap_valid;
   logic [DATA_W-1:0] c00;
   logic [DATA_W-1:0] c01;
   logic [DATA_W-1:0] c10;
   logic [DATA_W-1:0] c11;
   logic              cap_ready;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic [1:0]        m_idx;
   logic              m_last;
   logic              ovf;
   logic              ovf_clr;
   logic [CNT_W-1:0]  frame_cnt;
`ifdef MATDRAIN_PARITY_EN
   logic              m_parity;
`endif

   modport master (
      input  cap_valid, c00, c01, c10, c11, m_ready, ovf_clr,
      output cap_ready, m_valid, m_data, m_idx, m_last, ovf, frame_cnt
`ifdef MATDRAIN_PARITY_EN
      , output m_parity
`endif
   );

   modport slave (
      output cap_valid, c00, c01, c10, c11, m_ready, ovf_clr,
      input  cap_ready, m_valid, m_data, m_idx, m_last, ovf, frame_cnt
`ifdef MATDRAIN_PARITY_EN
      , input m_parity
`endif
   );
endinterface

// File: rtl/matmult_result_drain.sv
// matmult_result_drain: captures the four 2x2 product words on a capture strobe and streams them
// out row-major (c00, c01, c10, c11), one word per valid/ready beat.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - matmult_result_drain_if.master (capture, stream and status signals)
// A capture offered while a frame is still in flight (other than on its last beat) is dropped
// and latches the sticky ovf flag. frame_cnt counts completed frames and wraps.
// Optional feature macro: MATDRAIN_PARITY_EN adds m_parity = XOR of all bits of m_data.
module matmult_result_drain #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input logic                   clk,
   input logic                   rst,
   matmult_result_drain_if.master bus
);

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] h_q [4];
   logic [DATA_W-1:0] h_d [4];
   logic [1:0]        idx_q, idx_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              ovf_q, ovf_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic xfer;
   logic last_xfer;
   logic cap_ready;
   logic cap;
   logic drop;

   assign xfer      = valid_q & bus.m_ready;
   assign last_xfer = xfer & (idx_q == 2'd3);
   // Accepting a new frame on the last beat lets frames run back to back without a bubble.
   assign cap_ready = (state_q == StIdle) | ((state_q == StSend) & last_xfer);
   assign cap       = bus.cap_valid & cap_ready;
   assign drop      = bus.cap_valid & ~cap_ready;

   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;

      if (cap) begin
         h_d[0]  = bus.c00;
         h_d[1]  = bus.c01;
         h_d[2]  = bus.c10;
         h_d[3]  = bus.c11;
         idx_d   = 2'd0;
         valid_d = 1'b1;
         state_d = StSend;
      end else if (xfer) begin
         if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            valid_d = 1'b0;
            state_d = StIdle;
         end else begin
            idx_d = idx_q + 2'd1;
         end
      end

      if (last_xfer) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
         ovf_d = 1'b1;
      end else if (bus.ovf_clr) begin
         ovf_d = 1'b0;
      end

      // m_data is registered straight from the next-state holding word so it never glitches.
      data_d = h_d[idx_d];
   end

`ifdef MATDRAIN_PARITY_EN
   logic parity_q, parity_d;
   assign parity_d     = ^data_d;
   assign bus.m_parity = parity_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         for (int i = 0; i < 4; i++) begin
            h_q[i] <= '0;
         end
         idx_q   <= 2'd0;
         valid_q <= 1'b0;
         data_q  <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
`ifdef MATDRAIN_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
`ifdef MATDRAIN_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign bus.cap_ready = cap_ready;
   assign bus.m_valid   = valid_q;
   assign bus.m_data    = data_q;
   assign bus.m_idx     = idx_q;
   assign bus.m_last    = valid_q & (idx_q == 2'd3);
   assign bus.ovf       = ovf_q;
   assign bus.frame_cnt = cnt_q;

endmodule

// File: tb/tb_matmult_result_drain.sv
module tb_matmult_result_drain;

   typedef struct {
      logic [31:0] d;
      logic [1:0]  i;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   passes = 0;
   int   exp_cnt = 0;
   beat_t sb[$];

   matmult_result_drain_if #(.DATA_W(32), .CNT_W(16)) bus ();

   matmult_result_drain #(.DATA_W(32), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_cap(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d);
      bus.c00 = a;
      bus.c01 = b;
      bus.c10 = c;
      bus.c11 = d;
      bus.cap_valid = 1'b1;
   endtask

   task automatic push_frame(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [31:0] d);
      beat_t e;
      e.d = a; e.i = 2'd0; sb.push_back(e);
      e.d = b; e.i = 2'd1; sb.push_back(e);
      e.d = c; e.i = 2'd2; sb.push_back(e);
      e.d = d; e.i = 2'd3; sb.push_back(e);
   endtask

   task automatic test_reset();
      bus.cap_valid = 1'b0;
      bus.c00 = '0; bus.c01 = '0; bus.c10 = '0; bus.c11 = '0;
      bus.m_ready = 1'b0;
      bus.ovf_clr = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (bus.m_valid !== 1'b0 || bus.m_idx !== 2'd0 || bus.m_last !== 1'b0 ||
          bus.m_data !== 32'd0 || bus.ovf !== 1'b0 || bus.frame_cnt !== 16'd0)
         $display("FAIL reset: valid=%b idx=%0d last=%b data=%h ovf=%b cnt=%0d, all should be 0",
                  bus.m_valid, bus.m_idx, bus.m_last, bus.m_data, bus.ovf, bus.frame_cnt);
      else passes++;
      checks++;
      if (bus.cap_ready !== 1'b1) $display("FAIL reset_cap_ready: got %b want 1", bus.cap_ready);
      else passes++;
   endtask

   task automatic test_single();
      beat_t e;
      int k;
      tick();
      drive_cap(32'd1, 32'd2, 32'd3, 32'd4);
      bus.m_ready = 1'b1;
      #1;
      checks++;
      if (bus.cap_ready !== 1'b1) $display("FAIL single_cap_ready: got %b want 1", bus.cap_ready);
      else passes++;
      push_frame(32'd1, 32'd2, 32'd3, 32'd4);
      k = 0;
      while (sb.size() > 0 && k < 20) begin
         tick();
         bus.cap_valid = 1'b0;
         #1;
         checks++;
         if (bus.m_valid !== 1'b1) $display("FAIL single_valid: cyc %0d got %b want 1", k, bus.m_valid);
         else passes++;
         if (bus.m_valid && bus.m_ready) begin
            e = sb.pop_front();
            checks++;
            if (bus.m_data !== e.d || bus.m_idx !== e.i || bus.m_last !== (e.i == 2'd3))
               $display("FAIL single_beat: got data=%h idx=%0d last=%b want data=%h idx=%0d",
                        bus.m_data, bus.m_idx, bus.m_last, e.d, e.i);
            else passes++;
         end
         k++;
      end
      checks++;
      if (sb.size() != 0 || k != 4) begin
         $display("FAIL single_timing: %0d beats left after %0d cycles, want 0 after 4", sb.size(), k);
         sb.delete();
      end else passes++;
      exp_cnt++;
      tick();
      #1;
      checks++;
      if (bus.m_valid !== 1'b0 || bus.frame_cnt !== 16'(exp_cnt) || bus.cap_ready !== 1'b1)
         $display("FAIL single_end: valid=%b cnt=%0d cap_ready=%b want 0 %0d 1",
                  bus.m_valid, bus.frame_cnt, bus.cap_ready, exp_cnt);
      else passes++;
   endtask

   task automatic test_backpressure();
      beat_t e;
      int k;
      tick();
      drive_cap(32'hA, 32'hB, 32'hC, 32'hD);
      bus.m_ready = 1'b1;
      push_frame(32'hA, 32'hB, 32'hC, 32'hD);
      k = 0;
      while (sb.size() > 0 && k < 20) begin
         tick();
         bus.cap_valid = 1'b0;
         bus.m_ready = !(k >= 1 && k <= 3);
         #1;
         if (!bus.m_ready) begin
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== 32'hB || bus.m_idx !== 2'd1)
               $display("FAIL bp_hold: cyc %0d got valid=%b data=%h idx=%0d want 1 0000000b 1",
                        k, bus.m_valid, bus.m_data, bus.m_idx);
            else passes++;
         end
         if (bus.m_valid && bus.m_ready) begin
            e = sb.pop_front();
            checks++;
            if (bus.m_data !== e.d || bus.m_idx !== e.i || bus.m_last !== (e.i == 2'd3))
               $display("FAIL bp_beat: got data=%h idx=%0d last=%b want data=%h idx=%0d",
                        bus.m_data, bus.m_idx, bus.m_last, e.d, e.i);
            else passes++;
         end
         k++;
      end
      checks++;
      if (sb.size() != 0 || k != 7) begin
         $display("FAIL bp_timing: %0d beats left after %0d cycles, want 0 after 7", sb.size(), k);
         sb.delete();
      end else passes++;
      exp_cnt++;
      bus.m_ready = 1'b1;
   endtask

   task automatic test_back_to_back();
      beat_t e;
      int k;
      tick();
      drive_cap(32'd5, 32'd6, 32'd7, 32'd8);
      bus.m_ready = 1'b1;
      push_frame(32'd5, 32'd6, 32'd7, 32'd8);
      k = 0;
      while (sb.size() > 0 && k < 20) begin
         tick();
         bus.cap_valid = 1'b0;
         if (k == 3) drive_cap(32'd9, 32'd10, 32'd11, 32'd12);
         #1;
         if (k == 3) begin
            checks++;
            if (bus.cap_ready !== 1'b1) $display("FAIL b2b_cap_ready: got %b want 1", bus.cap_ready);
            else passes++;
            push_frame(32'd9, 32'd10, 32'd11, 32'd12);
         end
         checks++;
         if (bus.m_valid !== 1'b1) $display("FAIL b2b_bubble: cyc %0d valid=%b want 1", k, bus.m_valid);
         else passes++;
         if (bus.m_valid && bus.m_ready) begin
            e = sb.pop_front();
            checks++;
            if (bus.m_data !== e.d || bus.m_idx !== e.i || bus.m_last !== (e.i == 2'd3))
               $display("FAIL b2b_beat: got data=%h idx=%0d last=%b want data=%h idx=%0d",
                        bus.m_data, bus.m_idx, bus.m_last, e.d, e.i);
            else passes++;
         end
         k++;
      end
      checks++;
      if (sb.size() != 0 || k != 8) begin
         $display("FAIL b2b_timing: %0d beats left after %0d cycles, want 0 after 8", sb.size(), k);
         sb.delete();
      end else passes++;
      exp_cnt += 2;
      tick();
      #1;
      checks++;
      if (bus.m_valid !== 1'b0 || bus.frame_cnt !== 16'(exp_cnt) || bus.ovf !== 1'b0)
         $display("FAIL b2b_end: valid=%b cnt=%0d ovf=%b want 0 %0d 0",
                  bus.m_valid, bus.frame_cnt, bus.ovf, exp_cnt);
      else passes++;
   endtask

   task automatic test_overflow();
      beat_t e;
      int k;
      tick();
      drive_cap(32'h10, 32'h11, 32'h12, 32'h13);
      bus.m_ready = 1'b1;
      push_frame(32'h10, 32'h11, 32'h12, 32'h13);
      k = 0;
      while (sb.size() > 0 && k < 20) begin
         tick();
         bus.cap_valid = 1'b0;
         bus.ovf_clr = 1'b0;
         bus.m_ready = 1'b1;
         if (k == 1 || k == 3) begin
            // Offer a capture mid-frame while stalled; it must be dropped.
            drive_cap(32'hFF, 32'hFF, 32'hFF, 32'hFF);
            bus.m_ready = 1'b0;
            bus.ovf_clr = (k == 3);
         end
         if (k == 4) bus.ovf_clr = 1'b1;
         #1;
         if (k == 1 || k == 3) begin
            checks++;
            if (bus.cap_ready !== 1'b0) $display("FAIL ovf_cap_ready: cyc %0d got %b want 0", k, bus.cap_ready);
            else passes++;
         end
         if (k >= 2) begin
            checks++;
            if (bus.ovf !== (k != 5)) $display("FAIL ovf_flag: cyc %0d got %b want %b", k, bus.ovf, k != 5);
            else passes++;
         end
         if (bus.m_valid && bus.m_ready) begin
            e = sb.pop_front();
            checks++;
            if (bus.m_data !== e.d || bus.m_idx !== e.i || bus.m_last !== (e.i == 2'd3))
               $display("FAIL ovf_beat: got data=%h idx=%0d last=%b want data=%h idx=%0d",
                        bus.m_data, bus.m_idx, bus.m_last, e.d, e.i);
            else passes++;
         end
         k++;
      end
      checks++;
      if (sb.size() != 0 || k != 6) begin
         $display("FAIL ovf_timing: %0d beats left after %0d cycles, want 0 after 6", sb.size(), k);
         sb.delete();
      end else passes++;
      bus.cap_valid = 1'b0;
      bus.ovf_clr = 1'b0;
      exp_cnt++;
   endtask

   task automatic test_reset_mid();
      beat_t e;
      int k;
      tick();
      drive_cap(32'h20, 32'h21, 32'h22, 32'h23);
      bus.m_ready = 1'b1;
      for (int j = 0; j < 3; j++) begin
         tick();
         bus.cap_valid = 1'b0;
         if (j == 1) drive_cap(32'hFF, 32'hFF, 32'hFF, 32'hFF);
         if (j == 2) begin
            rst = 1'b1;
            bus.m_ready = 1'b0;
         end
      end
      tick();
      rst = 1'b0;
      bus.m_ready = 1'b1;
      exp_cnt = 0;
      #1;
      checks++;
      if (bus.m_valid !== 1'b0 || bus.m_idx !== 2'd0 || bus.m_data !== 32'd0 ||
          bus.ovf !== 1'b0 || bus.frame_cnt !== 16'd0)
         $display("FAIL rst_mid: valid=%b idx=%0d data=%h ovf=%b cnt=%0d, all should be 0",
                  bus.m_valid, bus.m_idx, bus.m_data, bus.ovf, bus.frame_cnt);
      else passes++;
      tick();
      drive_cap(32'h31, 32'h32, 32'h33, 32'h34);
      push_frame(32'h31, 32'h32, 32'h33, 32'h34);
      k = 0;
      while (sb.size() > 0 && k < 20) begin
         tick();
         bus.cap_valid = 1'b0;
         #1;
         if (bus.m_valid && bus.m_ready) begin
            e = sb.pop_front();
            checks++;
            if (bus.m_data !== e.d || bus.m_idx !== e.i || bus.m_last !== (e.i == 2'd3))
               $display("FAIL rst_mid_beat: got data=%h idx=%0d last=%b want data=%h idx=%0d",
                        bus.m_data, bus.m_idx, bus.m_last, e.d, e.i);
            else passes++;
         end
         k++;
      end
      checks++;
      if (sb.size() != 0) begin
         $display("FAIL rst_mid_timeout: %0d beats left, want 0", sb.size());
         sb.delete();
      end else passes++;
      exp_cnt++;
      tick();
      #1;
      checks++;
      if (bus.frame_cnt !== 16'(exp_cnt)) $display("FAIL rst_mid_cnt: got %0d want %0d", bus.frame_cnt, exp_cnt);
      else passes++;
   endtask

`ifdef MATDRAIN_PARITY_EN
   task automatic test_parity();
      beat_t e;
      int k;
      tick();
      drive_cap(32'h1, 32'h3, 32'h7, 32'h0);
      bus.m_ready = 1'b1;
      push_frame(32'h1, 32'h3, 32'h7, 32'h0);
      k = 0;
      while (sb.size() > 0 && k < 20) begin
         tick();
         bus.cap_valid = 1'b0;
         bus.m_ready = (k != 1);
         #1;
         if (bus.m_valid) begin
            e = sb[0];
            checks++;
            if (bus.m_parity !== (^e.d)) $display("FAIL parity: data %h got %b want %b", e.d, bus.m_parity, ^e.d);
            else passes++;
         end
         if (bus.m_valid && bus.m_ready) e = sb.pop_front();
         k++;
      end
      checks++;
      if (sb.size() != 0) begin
         $display("FAIL parity_timeout: %0d beats left, want 0", sb.size());
         sb.delete();
      end else passes++;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_overflow();
      test_reset_mid();
`ifdef MATDRAIN_PARITY_EN
      test_parity();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
